// File: rtl/verifier_collect_w_beta_if.sv
// Challenge-collection / beta-engine handshake bundle for verifier_collect_w_beta.
// slave = collector side, master = stimulus/engine side.
interface verifier_collect_w_beta_if #(
  parameter int nCopyBits = 3,
  parameter int F_NBITS   = 32
);
  logic                              clear;
  logic                              w_valid;
  logic [F_NBITS-1:0]                w_in;
  logic [nCopyBits-1:0][F_NBITS-1:0] w_vals;
  logic                              full;
  logic                              overflow;
  logic                              beta_en;
  logic                              beta_ready;
  logic [F_NBITS-1:0]                beta_in;
  logic                              beta_valid;
  logic [F_NBITS-1:0]                beta_out;

  modport slave (
    input  clear, w_valid, w_in, beta_ready, beta_in,
    output w_vals, full, overflow, beta_en, beta_valid, beta_out
  );

  modport master (
    output clear, w_valid, w_in, beta_ready, beta_in,
    input  w_vals, full, overflow, beta_en, beta_valid, beta_out
  );
endinterface

// File: rtl/verifier_collect_w_beta.sv
// Collects nCopyBits challenges, pulses beta_en 2 cycles after the last one, latches beta on engine ready.
// No backpressure on w: challenges arriving outside collection are dropped and flagged in sticky overflow.
module verifier_collect_w_beta #(
  parameter int nCopyBits = 3,
  parameter int F_NBITS   = 32
) (
  input  logic                      clk,
  input  logic                      rstb,
  verifier_collect_w_beta_if.slave  bus
);
  localparam int CW = $clog2(nCopyBits + 1);

  typedef enum logic [1:0] {ST_FILL, ST_LAUNCH, ST_WAIT, ST_DONE} state_t;

  state_t                            r_state, w_state_nxt;
  logic [CW-1:0]                     r_count, w_count_nxt;
  logic [nCopyBits-1:0][F_NBITS-1:0] r_w_vals;
  logic                              r_full, w_full_nxt;
  logic                              r_overflow, w_overflow_nxt;
  logic                              r_beta_en, w_beta_en_nxt;
  logic                              r_beta_valid, w_beta_valid_nxt;
  logic [F_NBITS-1:0]                r_beta_out, w_beta_out_nxt;
  logic                              r_clear_pend, w_clear_pend_nxt;
  logic                              w_capture;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state      <= ST_FILL;
      r_count      <= '0;
      r_w_vals     <= '0;
      r_full       <= 1'b0;
      r_overflow   <= 1'b0;
      r_beta_en    <= 1'b0;
      r_beta_valid <= 1'b0;
      r_beta_out   <= '0;
      r_clear_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_full       <= w_full_nxt;
      r_overflow   <= w_overflow_nxt;
      r_beta_en    <= w_beta_en_nxt;
      r_beta_valid <= w_beta_valid_nxt;
      r_beta_out   <= w_beta_out_nxt;
      r_clear_pend <= w_clear_pend_nxt;
      if (w_capture) r_w_vals[r_count] <= bus.w_in;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_count_nxt      = r_count;
    w_full_nxt       = r_full;
    w_overflow_nxt   = r_overflow;
    w_beta_en_nxt    = 1'b0;
    w_beta_valid_nxt = r_beta_valid;
    w_beta_out_nxt   = r_beta_out;
    w_clear_pend_nxt = r_clear_pend;
    w_capture        = 1'b0;

    if (bus.w_valid && !bus.clear && (r_state != ST_FILL || r_clear_pend))
      w_overflow_nxt = 1'b1;

    case (r_state)
      ST_FILL: begin
        if (bus.clear) begin
          w_count_nxt      = '0;
          w_full_nxt       = 1'b0;
          w_beta_valid_nxt = 1'b0;
          w_overflow_nxt   = 1'b0;
        end else if (bus.w_valid) begin
          w_capture   = 1'b1;
          w_count_nxt = CW'(r_count + 1'b1);
          if (r_count == CW'(nCopyBits - 1)) begin
            w_full_nxt  = 1'b1;
            w_state_nxt = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: begin
        if (bus.clear) begin
          w_count_nxt      = '0;
          w_full_nxt       = 1'b0;
          w_beta_valid_nxt = 1'b0;
          w_overflow_nxt   = 1'b0;
          w_state_nxt      = ST_FILL;
        end else begin
          w_beta_en_nxt = 1'b1;
          w_state_nxt   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The engine cannot be aborted: a clear here only marks the result for discard.
        if (bus.clear) begin
          w_clear_pend_nxt = 1'b1;
          w_overflow_nxt   = 1'b0;
        end
        if (bus.beta_ready) begin
          if (r_clear_pend || bus.clear) begin
            w_count_nxt      = '0;
            w_full_nxt       = 1'b0;
            w_beta_valid_nxt = 1'b0;
            w_clear_pend_nxt = 1'b0;
            w_state_nxt      = ST_FILL;
          end else begin
            w_beta_out_nxt   = bus.beta_in;
            w_beta_valid_nxt = 1'b1;
            w_state_nxt      = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (bus.clear) begin
          w_count_nxt      = '0;
          w_full_nxt       = 1'b0;
          w_beta_valid_nxt = 1'b0;
          w_overflow_nxt   = 1'b0;
          w_state_nxt      = ST_FILL;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  assign bus.w_vals     = r_w_vals;
  assign bus.full       = r_full;
  assign bus.overflow   = r_overflow;
  assign bus.beta_en    = r_beta_en;
  assign bus.beta_valid = r_beta_valid;
  assign bus.beta_out   = r_beta_out;
endmodule

// File: tb/tb_verifier_collect_w_beta.sv
// Directed bench for verifier_collect_w_beta with a behavioural beta engine (fixed or computed result).
module tb_verifier_collect_w_beta;
  localparam int N  = 3;
  localparam int FW = 32;

  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  verifier_collect_w_beta_if #(.nCopyBits(N), .F_NBITS(FW)) bus ();

  verifier_collect_w_beta #(.nCopyBits(N), .F_NBITS(FW)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Engine model: ready drops combinationally with en, result after eng_lat cycles.
  logic          eng_busy;
  int            eng_cnt;
  logic [FW-1:0] eng_res;
  logic [FW-1:0] eng_fixed;
  int            eng_lat;
  int            en_cnt = 0;
  int            en_base;

  function automatic logic [FW-1:0] beta_fn(input logic [N-1:0][FW-1:0] w);
    int p, wi, zi;
    p = 1;
    for (int i = 0; i < N; i++) begin
      wi = int'(w[i]);
      zi = (i == 0) ? 2 : (i == 1) ? 3 : 1;
      p  = p * (wi * zi + (1 - wi) * (1 - zi));
    end
    return FW'(p);
  endfunction

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      eng_busy <= 1'b0;
      eng_cnt  <= 0;
      eng_res  <= '0;
    end else if (bus.beta_en) begin
      eng_busy <= 1'b1;
      eng_cnt  <= eng_lat;
    end else if (eng_busy) begin
      if (eng_cnt <= 1) begin
        eng_busy <= 1'b0;
        eng_res  <= (eng_fixed != 0) ? eng_fixed : beta_fn(bus.w_vals);
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  always_ff @(posedge clk) if (bus.beta_en) en_cnt <= en_cnt + 1;

  assign bus.beta_ready = !eng_busy && !bus.beta_en;
  assign bus.beta_in    = eng_res;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_w(input logic [FW-1:0] v);
    bus.w_valid = 1'b1;
    bus.w_in    = v;
    tick();
    bus.w_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!bus.beta_valid && k < 80) begin
      tick();
      k++;
    end
    chk(tag, bus.beta_valid, 1'b1);
  endtask

  function automatic logic [N-1:0][FW-1:0] mk(input logic [FW-1:0] a, b, c);
    logic [N-1:0][FW-1:0] r;
    r[0] = a;
    r[1] = b;
    r[2] = c;
    return r;
  endfunction

  initial begin
    int k;
    rstb        = 1'b0;
    bus.clear   = 1'b0;
    bus.w_valid = 1'b0;
    bus.w_in    = '0;
    eng_fixed   = 42;
    eng_lat     = 4;
    idle(2);
    rstb = 1'b1;
    tick();

    // 1: back-to-back capture and launch timing
    chk("rst_full", bus.full, 1'b0);
    chk("rst_ovf", bus.overflow, 1'b0);
    chk("rst_en", bus.beta_en, 1'b0);
    chk("rst_bvld", bus.beta_valid, 1'b0);
    chk("rst_bout", bus.beta_out, 0);
    chk("rst_wvals", bus.w_vals, 0);
    en_base = en_cnt;
    send_w(5); send_w(7); send_w(9);
    chk("t1_full", bus.full, 1'b1);
    chk("t1_wvals", bus.w_vals, mk(5, 7, 9));
    chk("t1_en_early", bus.beta_en, 1'b0);
    tick();
    chk("t1_en", bus.beta_en, 1'b1);
    chk("t1_rdy_drop", bus.beta_ready, 1'b0);
    tick();
    chk("t1_en_off", bus.beta_en, 1'b0);
    wait_valid("t1_vld");
    chk("t1_bout", bus.beta_out, 42);
    idle(5);
    chk("t1_hold_vld", bus.beta_valid, 1'b1);
    chk("t1_hold_bout", bus.beta_out, 42);
    chk("t1_npulse", en_cnt - en_base, 1);

    // 2: gapped challenges
    pulse_clear();
    chk("t2_clr_full", bus.full, 1'b0);
    chk("t2_clr_vld", bus.beta_valid, 1'b0);
    chk("t2_clr_bout", bus.beta_out, 42);
    eng_fixed = 77;
    en_base = en_cnt;
    send_w(11); idle(2); send_w(22); idle(5); send_w(33);
    chk("t2_wvals", bus.w_vals, mk(11, 22, 33));
    chk("t2_en_early", bus.beta_en, 1'b0);
    tick();
    chk("t2_en", bus.beta_en, 1'b1);
    wait_valid("t2_vld");
    chk("t2_bout", bus.beta_out, 77);
    chk("t2_npulse", en_cnt - en_base, 1);

    // 3: extra challenge while the engine runs
    pulse_clear();
    eng_fixed = 66;
    eng_lat   = 10;
    send_w(1); send_w(2); send_w(3);
    idle(2);
    send_w(99);
    chk("t3_ovf", bus.overflow, 1'b1);
    chk("t3_wvals", bus.w_vals, mk(1, 2, 3));
    wait_valid("t3_vld");
    chk("t3_bout", bus.beta_out, 66);
    chk("t3_ovf_hold", bus.overflow, 1'b1);
    pulse_clear();
    chk("t3_clr_ovf", bus.overflow, 1'b0);
    chk("t3_clr_full", bus.full, 1'b0);
    chk("t3_clr_vld", bus.beta_valid, 1'b0);

    // 4: clear while waiting discards the result
    eng_fixed = 55;
    eng_lat   = 20;
    en_base = en_cnt;
    send_w(4); send_w(5); send_w(6);
    idle(3);
    pulse_clear();
    chk("t4_vld_pend", bus.beta_valid, 1'b0);
    k = 0;
    while (!bus.beta_ready && k < 60) begin
      tick();
      k++;
    end
    chk("t4_ready_seen", bus.beta_ready, 1'b1);
    tick();
    chk("t4_vld", bus.beta_valid, 1'b0);
    chk("t4_bout", bus.beta_out, 66);
    chk("t4_full", bus.full, 1'b0);
    chk("t4_npulse", en_cnt - en_base, 1);
    send_w(8);
    chk("t4_w0", bus.w_vals[0], 8);
    chk("t4_w1", bus.w_vals[1], 5);

    // 5: clear beats a simultaneous final challenge
    pulse_clear();
    en_base = en_cnt;
    send_w(1); send_w(2);
    bus.clear   = 1'b1;
    bus.w_valid = 1'b1;
    bus.w_in    = 3;
    tick();
    bus.clear   = 1'b0;
    bus.w_valid = 1'b0;
    chk("t5_full", bus.full, 1'b0);
    chk("t5_w2", bus.w_vals[2], 6);
    chk("t5_ovf", bus.overflow, 1'b0);
    idle(4);
    chk("t5_npulse", en_cnt - en_base, 0);
    send_w(7);
    chk("t5_w0", bus.w_vals[0], 7);
    chk("t5_full2", bus.full, 1'b0);

    // 6: async reset mid-wait, then a computed beta
    pulse_clear();
    eng_fixed = 0;
    eng_lat   = 15;
    send_w(1); send_w(2); send_w(3);
    idle(3);
    #2 rstb = 1'b0;
    #1;
    chk("t6_rst_full", bus.full, 1'b0);
    chk("t6_rst_bout", bus.beta_out, 0);
    chk("t6_rst_wvals", bus.w_vals, 0);
    chk("t6_rst_en", bus.beta_en, 1'b0);
    chk("t6_rst_vld", bus.beta_valid, 1'b0);
    tick();
    rstb = 1'b1;
    tick();
    en_base = en_cnt;
    send_w(1); send_w(2); send_w(3);
    chk("t6_full", bus.full, 1'b1);
    tick();
    chk("t6_en", bus.beta_en, 1'b1);
    wait_valid("t6_vld");
    chk("t6_beta", bus.beta_out, 48);
    chk("t6_npulse", en_cnt - en_base, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
